fetch_queue: RTL and testbench

Parametrised, decoupled instruction-fetch front end for the superscalar core. It issues aligned multi-instruction fetch requests to instruction memory, using a request/grant, in-order-response protocol with multiple requests in flight. Fetched instructions are buffered in a circular fetch queue, and up to FETCH_WIDTH of the oldest are presented to decode under a valid/ready handshake. Redirects flush the queue, discard stale in-flight responses, and handle redirect targets that are not aligned to a fetch block.

---
 rtl/core_pkg.sv | 25 ++
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue_req_fifo.sv | 64 ++++++
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared core widths and fetch-path record types.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN                = 32;
  localparam int FETCH_WIDTH_DEFAULT = 2;
  // Wide enough for fetch blocks of up to 16 instructions.
  localparam int LANE_IDX_W          = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN-1:0]       base;
    logic [LANE_IDX_W-1:0] start_lane;
  } fetch_tag_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_if
// Brief    : Instruction-memory request/response bus plus the decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                               imem_req_o;
  logic [ADDR_WIDTH-1:0]              imem_addr_o;
  logic                               imem_gnt_i;
  logic                               imem_rvalid_i;
  logic [FETCH_WIDTH*INSTR_WIDTH-1:0] imem_rdata_i;
  logic [FETCH_WIDTH-1:0]             if_valid_o;
  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]  if_pc_o;
  logic [FETCH_WIDTH*INSTR_WIDTH-1:0] if_instr_o;
  logic                               if_ready_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output if_valid_o, if_pc_o, if_instr_o,
    input  if_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  if_valid_o, if_pc_o, if_instr_o,
    output if_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_req_fifo
// Brief    : Small FIFO of in-flight fetch tags with synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_req_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  fetch_tag_t push_tag_i,
  input  logic       pop_i,
  output fetch_tag_t head_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

  fetch_tag_t         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == c_cnt_w'(DEPTH));
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= f_next(r_wptr);
      if (w_pop)  r_rptr <= f_next(r_rptr);
      r_cnt <= r_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_tag_i;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Decoupled fetch front end: credit-gated block requests, circular
//            instruction queue, multi-lane decode presentation, redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import core_pkg::*;
#(
  parameter int                    FETCH_WIDTH  = FETCH_WIDTH_DEFAULT,
  parameter int                    ADDR_WIDTH   = XLEN,
  parameter int                    INSTR_WIDTH  = XLEN,
  parameter int                    QUEUE_DEPTH  = 8,
  parameter int                    MAX_INFLIGHT = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          fetch_en_i,
  input  logic                          redirect_i,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc_i,
  fetch_queue_if.master                 bus,
  output logic [$clog2(QUEUE_DEPTH):0]  occupancy_o
);
  localparam int c_ptr_w     = $clog2(QUEUE_DEPTH);
  localparam int c_cnt_w     = c_ptr_w + 1;
  localparam int c_blk_bytes = FETCH_WIDTH * 4;
  localparam int c_off_bits  = $clog2(c_blk_bytes);
  localparam int c_out_w     = $clog2(MAX_INFLIGHT + 1);
  localparam logic [c_cnt_w-1:0] c_fw_cnt = c_cnt_w'(FETCH_WIDTH);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [c_out_w-1:0]    r_outstanding;
  logic [c_out_w-1:0]    r_drop;
  logic [c_ptr_w-1:0]    r_wptr;
  logic [c_ptr_w-1:0]    r_rptr;
  logic [c_cnt_w-1:0]    r_count;
  fetch_entry_t          r_queue [QUEUE_DEPTH];

  logic [ADDR_WIDTH-1:0] w_base;
  logic [LANE_IDX_W-1:0] w_start_lane;
  logic [31:0]           w_free;
  logic [31:0]           w_need;
  logic                  w_req;
  logic                  w_fire;
  logic                  w_deliver;
  logic [c_cnt_w-1:0]    w_enq_cnt;
  logic [c_cnt_w-1:0]    w_deq_cnt;
  logic [c_out_w-1:0]    w_rvalid_cnt;
  fetch_tag_t            w_head;
  logic                  w_tag_empty;
  logic                  w_tag_full;

  assign w_base       = {r_pc[ADDR_WIDTH-1:c_off_bits], {c_off_bits{1'b0}}};
  assign w_start_lane = LANE_IDX_W'((r_pc & ADDR_WIDTH'(c_blk_bytes - 1)) >> 2);

  // Credit: reserve a full block of space for every request that could land.
  assign w_free = 32'(QUEUE_DEPTH) - 32'(r_count);
  assign w_need = (32'(r_outstanding) + 32'd1) * 32'(FETCH_WIDTH);
  assign w_req  = rst_ni & fetch_en_i & ~redirect_i & ~w_tag_full
                & (32'(r_outstanding) < 32'(MAX_INFLIGHT)) & (w_free >= w_need);
  assign w_fire = w_req & bus.imem_gnt_i;

  assign w_rvalid_cnt = c_out_w'(bus.imem_rvalid_i);
  assign w_deliver    = bus.imem_rvalid_i & ~redirect_i & (r_drop == '0) & ~w_tag_empty;
  assign w_enq_cnt    = w_deliver ? c_cnt_w'(FETCH_WIDTH - int'(w_head.start_lane)) : '0;
  assign w_deq_cnt    = (bus.if_ready_i & ~redirect_i)
                      ? ((r_count < c_fw_cnt) ? r_count : c_fw_cnt) : '0;

  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = w_base;
  assign occupancy_o     = r_count;

  fetch_req_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_req_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (redirect_i),
    .push_i     (w_fire),
    .push_tag_i ('{base: XLEN'(w_base), start_lane: w_start_lane}),
    .pop_i      (w_deliver),
    .head_o     (w_head),
    .empty_o    (w_tag_empty),
    .full_o     (w_tag_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else if (redirect_i) begin
      // Everything still owed after this cycle belongs to the old path.
      r_pc          <= redirect_pc_i;
      r_outstanding <= r_outstanding - w_rvalid_cnt;
      r_drop        <= r_outstanding - w_rvalid_cnt;
      r_rptr        <= r_wptr;
      r_count       <= '0;
    end else begin
      if (w_fire) r_pc <= w_base + ADDR_WIDTH'(c_blk_bytes);
      r_outstanding <= r_outstanding + c_out_w'(w_fire) - w_rvalid_cnt;
      if (bus.imem_rvalid_i && (r_drop != '0)) r_drop <= r_drop - c_out_w'(1);
      r_wptr  <= r_wptr + c_ptr_w'(w_enq_cnt);
      r_rptr  <= r_rptr + c_ptr_w'(w_deq_cnt);
      r_count <= r_count + w_enq_cnt - w_deq_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_deliver) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (i >= int'(w_head.start_lane)) begin
          r_queue[r_wptr + c_ptr_w'(i - int'(w_head.start_lane))].pc <=
            XLEN'(w_head.base[ADDR_WIDTH-1:0] + ADDR_WIDTH'(4 * i));
          r_queue[r_wptr + c_ptr_w'(i - int'(w_head.start_lane))].instr <=
            XLEN'(bus.imem_rdata_i[i*INSTR_WIDTH +: INSTR_WIDTH]);
        end
      end
    end
  end

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    fetch_entry_t w_ent;
    logic         w_valid;
    assign w_ent   = r_queue[r_rptr + c_ptr_w'(g)];
    assign w_valid = (r_count > c_cnt_w'(g));
    assign bus.if_valid_o[g] = w_valid;
    assign bus.if_pc_o[g*ADDR_WIDTH +: ADDR_WIDTH] =
      w_valid ? w_ent.pc[ADDR_WIDTH-1:0] : '0;
    assign bus.if_instr_o[g*INSTR_WIDTH +: INSTR_WIDTH] =
      w_valid ? w_ent.instr[INSTR_WIDTH-1:0] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Randomised bench for fetch_queue against a queue-based fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [3:0]  occupancy;

  always #5 clk = ~clk;

  fetch_queue_if #(.FETCH_WIDTH(2), .ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_queue #(
    .FETCH_WIDTH  (2),
    .ADDR_WIDTH   (32),
    .INSTR_WIDTH  (32),
    .QUEUE_DEPTH  (8),
    .MAX_INFLIGHT (2),
    .RESET_PC     (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_en_i    (fetch_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .bus           (bus),
    .occupancy_o   (occupancy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: next fetch PC, expected instruction stream, memory requests owed.
  logic [31:0] m_pc;
  logic [31:0] mq_pc[$];
  logic [31:0] pend_addr[$];
  int          pend_start[$];
  bit          pend_stale[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_outputs(input bit exp_req);
    int          n;
    logic [1:0]  ev;
    logic [63:0] epc;
    logic [63:0] ein;
    n   = (mq_pc.size() < 2) ? mq_pc.size() : 2;
    ev  = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    epc = '0;
    ein = '0;
    for (int i = 0; i < n; i++) begin
      epc[i*32 +: 32] = mq_pc[i];
      ein[i*32 +: 32] = word(mq_pc[i]);
    end
    check("imem_req", 64'(bus.imem_req_o), 64'(exp_req));
    check("imem_addr", 64'(bus.imem_addr_o), 64'(m_pc & ~32'h7));
    check("if_valid", 64'(bus.if_valid_o), 64'(ev));
    check("if_pc", bus.if_pc_o, epc);
    check("if_instr", bus.if_instr_o, ein);
    check("occupancy", 64'(occupancy), 64'(mq_pc.size()));
  endtask

  // One clock of stimulus, comparison and model update.
  task automatic cycle(input bit en, input bit redir, input logic [31:0] rpc,
                       input bit gnt, input bit rv, input bit rdy);
    bit          rv_now;
    bit          exp_req;
    bit          stale;
    int          n;
    int          st;
    logic [31:0] a;
    logic [31:0] base;
    logic [31:0] tmp;
    @(negedge clk);
    fetch_en          = en;
    redirect          = redir;
    redirect_pc       = rpc;
    bus.imem_gnt_i    = gnt;
    bus.if_ready_i    = rdy;
    rv_now            = rv && (pend_addr.size() > 0);
    bus.imem_rvalid_i = rv_now;
    bus.imem_rdata_i  = rv_now ? {word(pend_addr[0] + 32'd4), word(pend_addr[0])} : '0;
    exp_req = en && !redir && (pend_addr.size() < 2)
              && ((8 - mq_pc.size()) >= (pend_addr.size() + 1) * 2);
    #1;
    compare_outputs(exp_req);
    n     = (mq_pc.size() < 2) ? mq_pc.size() : 2;
    a     = '0;
    st    = 0;
    stale = 1'b1;
    if (rv_now) begin
      a     = pend_addr.pop_front();
      st    = pend_start.pop_front();
      stale = pend_stale.pop_front();
    end
    if (redir) begin
      mq_pc.delete();
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
      m_pc = rpc;
    end else begin
      if (rdy) repeat (n) tmp = mq_pc.pop_front();
      if (rv_now && !stale)
        for (int i = st; i < 2; i++) mq_pc.push_back(a + 32'(4 * i));
      if (exp_req && gnt) begin
        base = m_pc & ~32'h7;
        pend_addr.push_back(base);
        pend_start.push_back(int'(m_pc[2]));
        pend_stale.push_back(1'b0);
        m_pc = base + 32'd8;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    rst_n             = 1'b0;
    fetch_en          = 1'b0;
    redirect          = 1'b0;
    redirect_pc       = '0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.if_ready_i    = 1'b0;
    m_pc              = 32'h0;

    #12;
    fetch_en = 1'b1;
    #1;
    check("rst_imem_req", 64'(bus.imem_req_o), 64'h0);
    check("rst_imem_addr", 64'(bus.imem_addr_o), 64'h0);
    check("rst_if_valid", 64'(bus.if_valid_o), 64'h0);
    check("rst_if_pc", bus.if_pc_o, 64'h0);
    check("rst_if_instr", bus.if_instr_o, 64'h0);
    check("rst_occupancy", 64'(occupancy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: first pair visible two cycles after the first grant.
    cycle(1, 0, 0, 1, 0, 1);
    @(posedge clk); #1;
    check("lit_addr_after_grant", 64'(bus.imem_addr_o), 64'h8);
    cycle(1, 0, 0, 1, 1, 1);
    @(posedge clk); #1;
    check("lit_first_valid", 64'(bus.if_valid_o), 64'h3);
    check("lit_first_pcs", bus.if_pc_o, 64'h0000_0004_0000_0000);
    repeat (20) cycle(1, 0, 0, 1, 1, 1);

    // Misaligned redirect with two requests outstanding.
    for (int k = 0; k < 10 && pend_addr.size() < 2; k++) cycle(1, 0, 0, 1, 0, 1);
    check("setup_two_outstanding", 64'(pend_addr.size()), 64'd2);
    cycle(1, 1, 32'h104, 1, 0, 1);
    @(posedge clk); #1;
    check("lit_redirect_occ", 64'(occupancy), 64'h0);
    check("lit_redirect_addr", 64'(bus.imem_addr_o), 64'h100);
    for (int k = 0; k < 20 && mq_pc.size() == 0; k++) cycle(1, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
    check("lit_partial_valid", 64'(bus.if_valid_o), 64'h1);
    check("lit_partial_pc0", 64'(bus.if_pc_o[31:0]), 64'h104);

    // Redirect coinciding with a response and a dequeue.
    for (int k = 0; k < 20 && !(mq_pc.size() > 0 && pend_addr.size() > 0); k++)
      cycle(1, 0, 0, 1, k[0], 0);
    check("setup_busy_redirect", 64'(mq_pc.size() > 0 && pend_addr.size() > 0), 64'h1);
    cycle(1, 1, 32'h200, 1, 1, 1);
    @(posedge clk); #1;
    check("lit_simul_occ", 64'(occupancy), 64'h0);
    for (int k = 0; k < 20 && mq_pc.size() == 0; k++) cycle(1, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
    check("lit_simul_pcs", bus.if_pc_o, 64'h0000_0204_0000_0200);

    // Backpressure: queue fills to capacity and requests stop.
    cycle(1, 1, 32'h1000, 0, 0, 0);
    repeat (30) cycle(1, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
    check("lit_full_occ", 64'(occupancy), 64'h8);
    check("lit_full_no_req", 64'(bus.imem_req_o), 64'h0);
    repeat (10) cycle(1, 0, 0, 1, 1, 1);

    // Grant withheld: address and PC must hold.
    repeat (3) cycle(1, 0, 0, 0, 1, 1);

    repeat (3000) begin
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4)
                                        : ($urandom & 32'h0000_FFFC);
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0, rpc,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0);
    end

    repeat (10) cycle(0, 0, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
